// File: rtl/riscv_fetch_stage.sv
// riscv_fetch_stage: IF stage, owns the PC, fetches words from imem,
// buffers in-order responses and presents {pc, instr} to decode.
//
// Ports
//   clk, reset            clock; async active-low reset
//   pc_init               boot PC (low bits forced to 0)
//   imem_req_*            fetch request channel (valid/ready, addr)
//   imem_rsp_*            in-order fetch responses (valid, data)
//   redirect_valid/_pc    flush queued/in-flight fetches, restart at pc
//   if_valid/_ready       handshake to decode
//   if_pc, if_instr       head of the fetch buffer
module riscv_fetch_stage #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_init,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [31:0]     if_instr
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [XLEN-1:0] addr_t;
    typedef logic [CW-1:0]   cnt_t;
    typedef logic [AW-1:0]   ptr_t;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        addr_t       pc;
        logic [31:0] instr;
    } fetch_t;

    state_t state;
    addr_t  pc;
    cnt_t   out_cnt;
    cnt_t   drop_cnt;

    fetch_t buf_q [DEPTH];
    ptr_t   buf_rd;
    ptr_t   buf_wr;
    cnt_t   buf_cnt;

    addr_t  pcq [DEPTH];
    ptr_t   pcq_rd;
    ptr_t   pcq_wr;

    logic   credit;
    logic   accept;
    logic   push;
    logic   pop;
    logic   unused_bits;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    // In-flight fetches (including ones to be dropped) plus
    // buffered entries never exceed DEPTH, so nothing overflows.
    assign credit = (int'(out_cnt) + int'(buf_cnt)) < DEPTH;

    assign imem_req_valid = (state == RUN) && !redirect_valid
                          && credit;
    assign imem_req_addr  = pc;
    assign accept         = imem_req_valid && imem_req_ready;

    // A response in a redirect cycle is stale, as is any response
    // still owed to a fetch issued before an earlier redirect.
    assign push = imem_rsp_valid && !redirect_valid
                && (drop_cnt == '0);

    assign if_valid = (buf_cnt != '0);
    assign pop      = if_valid && if_ready;
    assign if_pc    = buf_q[buf_rd].pc;
    assign if_instr = buf_q[buf_rd].instr;

    assign unused_bits = ^{pc_init[1:0], redirect_pc[1:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= BOOT;
            pc    <= {pc_init[XLEN-1:2], 2'b00};
        end else begin
            state <= RUN;
            unique case (1'b1)
                redirect_valid: pc <= {redirect_pc[XLEN-1:2], 2'b00};
                accept:         pc <= pc + addr_t'(4);
                default:        pc <= pc;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            out_cnt <= out_cnt + cnt_t'(accept)
                     - cnt_t'(imem_rsp_valid);
            // drop_cnt is always a subset of out_cnt, so after a
            // redirect every fetch still owed is stale.
            if (redirect_valid)
                drop_cnt <= out_cnt - cnt_t'(imem_rsp_valid);
            else if (imem_rsp_valid && (drop_cnt != '0))
                drop_cnt <= drop_cnt - cnt_t'(1);
        end
    end

    // PC of every accepted fetch, popped by every response (dropped
    // or not) so the queue stays aligned across redirects.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcq    <= '{default: '0};
            pcq_rd <= '0;
            pcq_wr <= '0;
        end else begin
            if (accept) begin
                pcq[pcq_wr] <= pc;
                pcq_wr      <= ptr_inc(pcq_wr);
            end
            if (imem_rsp_valid)
                pcq_rd <= ptr_inc(pcq_rd);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_q   <= '{default: '0};
            buf_rd  <= '0;
            buf_wr  <= '0;
            buf_cnt <= '0;
        end else if (redirect_valid) begin
            buf_rd  <= '0;
            buf_wr  <= '0;
            buf_cnt <= '0;
        end else begin
            if (push) begin
                buf_q[buf_wr] <= '{pc: pcq[pcq_rd], instr: imem_rsp_data};
                buf_wr        <= ptr_inc(buf_wr);
            end
            if (pop)
                buf_rd <= ptr_inc(buf_rd);
            buf_cnt <= buf_cnt + cnt_t'(push) - cnt_t'(pop);
        end
    end

    a_no_overflow: assert property (
        @(posedge clk) disable iff (!reset)
        !(push && !pop && (int'(buf_cnt) == DEPTH))
    );

    a_rsp_expected: assert property (
        @(posedge clk) disable iff (!reset)
        imem_rsp_valid |-> (out_cnt != '0)
    );

endmodule
